// File: rtl/conv_pkg.sv
// Shared encodings for the CNN accelerator command controller.
// Latency: n/a (constants and helpers only).
// Backpressure: n/a.
package conv_pkg;

    // Controller state register encoding
    localparam logic [1:0] ST_IDLE = 2'd0;
    localparam logic [1:0] ST_RUN  = 2'd1;
    localparam logic [1:0] ST_IRQ  = 2'd2;
    localparam logic [1:0] ST_ERR  = 2'd3;

    // Err_Cause codes
    localparam logic [1:0] ERR_NONE    = 2'b00;
    localparam logic [1:0] ERR_ILLEGAL = 2'b01;
    localparam logic [1:0] ERR_TIMEOUT = 2'b10;

    // Host acknowledge code used when the top is not overridden
    localparam logic [3:0] DEF_ACK_CODE = 4'b1111;

    // Width of an operation index; a single-op build still needs one bit
    function automatic int op_idx_w(input int num_ops);
        return (num_ops > 1) ? $clog2(num_ops) : 1;
    endfunction

endpackage

// File: rtl/run_timer.sv
// Saturating RUN-cycle counter with timeout compare and run-length capture.
// Latency: expiry flag is combinational from the counter; Run_Cycles updates on the leave-RUN edge.
// Backpressure: none; driven purely by controller strobes every cycle.
module run_timer
    import conv_pkg::*;
#(
    parameter int TIMEOUT_W = 24
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 i_launch,
    input  logic                 i_running,
    input  logic                 i_leave,
    input  logic [TIMEOUT_W-1:0] i_limit,
    output logic                 o_expired,
    output logic [TIMEOUT_W-1:0] o_run_cycles
);

    localparam logic [TIMEOUT_W-1:0] CNT_MAX = '1;

    logic [TIMEOUT_W-1:0] r_run_cnt;
    logic [TIMEOUT_W-1:0] w_cnt_inc;

    // Saturating +1; reused both for counting and for the captured run length
    assign w_cnt_inc = (r_run_cnt == CNT_MAX) ? CNT_MAX : (r_run_cnt + TIMEOUT_W'(1));

    // The current cycle is the last allowed one when the count reaches limit-1
    assign o_expired = (i_limit != '0) && (r_run_cnt == (i_limit - TIMEOUT_W'(1)));

    // Count RUN cycles, restarting from zero on every launch
    always_ff @(posedge clk) begin
        if (rst) begin
            r_run_cnt <= '0;
        end else if (i_launch) begin
            r_run_cnt <= '0;
        end else if (i_running) begin
            r_run_cnt <= w_cnt_inc;
        end
    end

    // Capture the length of the run that is ending (includes the exit cycle)
    always_ff @(posedge clk) begin
        if (rst) begin
            o_run_cycles <= '0;
        end else if (i_leave) begin
            o_run_cycles <= w_cnt_inc;
        end
    end

endmodule

// File: rtl/conv_ctrl_fsm.sv
// Command/interrupt controller: launches one of NUM_OPS operations, waits for completion, holds IRQ until acknowledged.
// Latency: launch pulses one cycle after Control is sampled; State lags the internal state by one cycle.
// Backpressure: none; Control is sampled every cycle and ignored outside IDLE/IRQ/ERR as appropriate.
module conv_ctrl_fsm
    import conv_pkg::*;
#(
    parameter int                  NUM_OPS   = 4,
    parameter int                  CTRL_W    = 4,
    parameter int                  TIMEOUT_W = 24,
    parameter logic [CTRL_W-1:0]   ACK_CODE  = CTRL_W'(DEF_ACK_CODE),
    parameter logic [NUM_OPS-1:0]  RD_MASK   = NUM_OPS'(4'b1111),
    parameter logic [NUM_OPS-1:0]  WR_MASK   = NUM_OPS'(4'b1110),
    parameter logic [NUM_OPS-1:0]  NEXT_MASK = NUM_OPS'(4'b0010)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic [CTRL_W-1:0]    Control,
    input  logic [NUM_OPS-1:0]   Complete,
    input  logic [TIMEOUT_W-1:0] Timeout_Limit,
    output logic [CTRL_W-1:0]    State,
    output logic [NUM_OPS-1:0]   Sign,
    output logic                 DMA_read_valid,
    output logic                 DMA_write_valid,
    output logic                 Next_Reg,
    output logic [1:0]           Err_Cause,
    output logic [TIMEOUT_W-1:0] Run_Cycles
);

    localparam int OP_W = op_idx_w(NUM_OPS);

    logic [1:0]        r_state;
    logic [1:0]        w_next_state;
    logic [OP_W-1:0]   r_op_id;
    logic [OP_W-1:0]   w_launch_idx;
    logic [CTRL_W-1:0] w_state_code;

    logic w_cmd_launch;
    logic w_cmd_ack;
    logic w_cmd_none;
    logic w_op_done;
    logic w_expired;
    logic w_launch;
    logic w_leave_run;
    logic w_irq_ack;
    logic w_running;

    // Host command decode: 1..NUM_OPS launches op Control-1
    assign w_cmd_launch = (Control != '0) && (Control <= CTRL_W'(NUM_OPS));
    assign w_cmd_ack    = (Control == ACK_CODE);
    assign w_cmd_none   = (Control == '0);
    assign w_launch_idx = OP_W'(Control - CTRL_W'(1));

    // Only the active op's completion bit matters
    assign w_op_done = Complete[r_op_id];
    assign w_running = (r_state == ST_RUN);

    // Next-state selection; completion has priority over timeout in RUN
    always_comb begin
        w_next_state = r_state;
        case (r_state)
            ST_IDLE: begin
                if (w_cmd_launch) begin
                    w_next_state = ST_RUN;
                end else if (!(w_cmd_none || w_cmd_ack)) begin
                    w_next_state = ST_ERR;
                end
            end
            ST_RUN: begin
                if (w_op_done) begin
                    w_next_state = ST_IRQ;
                end else if (w_expired) begin
                    w_next_state = ST_ERR;
                end
            end
            default: begin
                // IRQ and ERR both wait for the host acknowledge
                if (w_cmd_ack) begin
                    w_next_state = ST_IDLE;
                end
            end
        endcase
    end

    assign w_launch    = (r_state == ST_IDLE) && (w_next_state == ST_RUN);
    assign w_leave_run = w_running && (w_next_state != ST_RUN);
    assign w_irq_ack   = (r_state == ST_IRQ) && (w_next_state == ST_IDLE);

    run_timer #(
        .TIMEOUT_W (TIMEOUT_W)
    ) u_run_timer (
        .clk          (clk),
        .rst          (rst),
        .i_launch     (w_launch),
        .i_running    (w_running),
        .i_leave      (w_leave_run),
        .i_limit      (Timeout_Limit),
        .o_expired    (w_expired),
        .o_run_cycles (Run_Cycles)
    );

    // State register and active op index (latched only at launch)
    always_ff @(posedge clk) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_op_id <= '0;
        end else begin
            r_state <= w_next_state;
            if (w_launch) begin
                r_op_id <= w_launch_idx;
            end
        end
    end

    // Error cause: set on entry to ERR, cleared when the host acknowledges it
    always_ff @(posedge clk) begin
        if (rst) begin
            Err_Cause <= ERR_NONE;
        end else if ((r_state == ST_IDLE) && (w_next_state == ST_ERR)) begin
            Err_Cause <= ERR_ILLEGAL;
        end else if (w_running && (w_next_state == ST_ERR)) begin
            Err_Cause <= ERR_TIMEOUT;
        end else if ((r_state == ST_ERR) && (w_next_state == ST_IDLE)) begin
            Err_Cause <= ERR_NONE;
        end
    end

    // Status code presented to the host for the current state
    always_comb begin
        w_state_code = '0;
        case (r_state)
            ST_RUN:  w_state_code = CTRL_W'(r_op_id) + CTRL_W'(1);
            ST_IRQ:  w_state_code = ACK_CODE;
            ST_ERR:  w_state_code = ACK_CODE - CTRL_W'(1);
            default: w_state_code = '0;
        endcase
    end

    // Register the status code so State is glitch-free toward the host
    always_ff @(posedge clk) begin
        if (rst) begin
            State <= '0;
        end else begin
            State <= w_state_code;
        end
    end

    // One-cycle launch pulses: one-hot Sign plus per-op DMA enables
    always_ff @(posedge clk) begin
        if (rst || !w_launch) begin
            Sign            <= '0;
            DMA_read_valid  <= 1'b0;
            DMA_write_valid <= 1'b0;
        end else begin
            Sign            <= NUM_OPS'(1) << w_launch_idx;
            DMA_read_valid  <= RD_MASK[w_launch_idx];
            DMA_write_valid <= WR_MASK[w_launch_idx];
        end
    end

    // Advance pulse only when a NEXT-capable op is acknowledged from IRQ
    always_ff @(posedge clk) begin
        if (rst) begin
            Next_Reg <= 1'b0;
        end else begin
            Next_Reg <= w_irq_ack && NEXT_MASK[r_op_id];
        end
    end

endmodule
